// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples async BCK/LRCK/DATA in clk_sys and emits stereo PCM pairs.
// Latency: 2-FF sync + edge detect, outputs register on the 3rd clk_sys edge of a BCK rise; no backpressure.
module i2s_rx #(
  parameter int AUDIO_W = 16,
  parameter int CNT_W   = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               i2s_bck,
  input  logic               i2s_lrck,
  input  logic               i2s_data,
  output logic [AUDIO_W-1:0] left,
  output logic [AUDIO_W-1:0] right,
  output logic               sample_valid,
  output logic [CNT_W-1:0]   slot_bits
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // {bck, lrck, data} share one synchronizer so they stay mutually aligned.
  logic [2:0]         sync1_q, sync2_q;
  logic               bck_prev_q;
  logic [AUDIO_W-1:0] shift_q, shift_d;
  logic [AUDIO_W-1:0] left_hold_q, left_hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lrck_prev_q, lrck_prev_d;
  logic               armed_q, armed_d;
  logic               have_left_q, have_left_d;
  logic [AUDIO_W-1:0] left_q, left_d;
  logic [AUDIO_W-1:0] right_q, right_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   slot_bits_q, slot_bits_d;

  logic               bck_s, lrck_s, data_s, bck_rise;
  logic [AUDIO_W-1:0] shift_ins;
  logic [CNT_W-1:0]   cnt_inc;
  int                 cnt_int;

  assign bck_s    = sync2_q[2];
  assign lrck_s   = sync2_q[1];
  assign data_s   = sync2_q[0];
  assign bck_rise = bck_s & ~bck_prev_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    cnt_int   = int'(cnt_q);
    shift_ins = shift_q;
    // Bits beyond AUDIO_W never match an index, so long slots truncate.
    for (int i = 0; i < AUDIO_W; i++) begin
      if (cnt_int == AUDIO_W - 1 - i) shift_ins[i] = data_s;
    end
  end

  always_comb begin
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    cnt_d       = cnt_q;
    lrck_prev_d = lrck_prev_q;
    armed_d     = armed_q;
    have_left_d = have_left_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    slot_bits_d = slot_bits_q;
    if (bck_rise) begin
      if (lrck_s == lrck_prev_q) begin
        shift_d = shift_ins;
        cnt_d   = cnt_inc;
      end else begin
        // LRCK already flipped: this bit is the LSB of the slot that is ending.
        slot_bits_d = cnt_inc;
        if (armed_q && !lrck_prev_q) begin
          left_hold_d = shift_ins;
          have_left_d = 1'b1;
        end else if (armed_q && lrck_prev_q && have_left_q) begin
          left_d      = left_hold_q;
          right_d     = shift_ins;
          valid_d     = 1'b1;
          have_left_d = 1'b0;
        end
        shift_d     = '0;
        cnt_d       = '0;
        lrck_prev_d = lrck_s;
        armed_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      bck_prev_q  <= 1'b0;
      shift_q     <= '0;
      left_hold_q <= '0;
      cnt_q       <= '0;
      lrck_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      have_left_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      slot_bits_q <= '0;
    end else begin
      sync1_q     <= {i2s_bck, i2s_lrck, i2s_data};
      sync2_q     <= sync1_q;
      bck_prev_q  <= bck_s;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      cnt_q       <= cnt_d;
      lrck_prev_q <= lrck_prev_d;
      armed_q     <= armed_d;
      have_left_q <= have_left_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      slot_bits_q <= slot_bits_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign slot_bits    = slot_bits_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames bit by bit and checks against a slot-level reference model.
module tb_i2s_rx;
  localparam int AW = 16;
  localparam int CW = 6;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          bck, lrck, data;
  logic [AW-1:0] left, right;
  logic          sample_valid;
  logic [CW-1:0] slot_bits;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model: bits of the current slot kept in a queue, words formed at each LRCK change.
  bit            q_bits[$];
  logic          m_lp, m_armed, m_have;
  logic [AW-1:0] m_hold, m_left, m_right;
  int            m_slot, m_pulses;

  i2s_rx #(.AUDIO_W(AW), .CNT_W(CW)) dut (
    .clk_sys(clk_sys), .reset(reset), .i2s_bck(bck), .i2s_lrck(lrck), .i2s_data(data),
    .left(left), .right(right), .sample_valid(sample_valid), .slot_bits(slot_bits)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (sample_valid === 1'b1) pulse_cnt++;

  task automatic model_reset();
    q_bits.delete();
    m_lp = 0; m_armed = 0; m_have = 0;
    m_hold = '0; m_left = '0; m_right = '0; m_slot = 0;
  endtask

  task automatic model_rise(input logic l, input logic d);
    logic [AW-1:0] w;
    q_bits.push_back(d);
    if (l != m_lp) begin
      w = '0;
      for (int i = 0; i < q_bits.size() && i < AW; i++) w[AW-1-i] = q_bits[i];
      m_slot = (q_bits.size() > 63) ? 63 : q_bits.size();
      if (m_armed && m_lp == 1'b0) begin
        m_hold = w; m_have = 1;
      end else if (m_armed && m_have) begin
        m_left = m_hold; m_right = w; m_pulses++; m_have = 0;
      end
      q_bits.delete();
      m_lp = l;
      m_armed = 1;
    end
  endtask

  task automatic send_bit(input logic l, input logic d);
    @(negedge clk_sys);
    bck = 1'b0; lrck = l; data = d;
    repeat (3) @(negedge clk_sys);
    bck = 1'b1;
    model_rise(l, d);
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic send_word(input logic [31:0] w, input int n, input logic ws);
    for (int i = 0; i < n; i++) send_bit((i == n - 1) ? ~ws : ws, w[n-1-i]);
  endtask

  task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int n);
    send_word(lw, n, 1'b0);
    send_word(rw, n, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; bck = 1'b0; lrck = 1'b0; data = 1'b0;
    m_pulses = 0;
    model_reset();
    repeat (4) @(negedge clk_sys);
    checks++; if (left !== '0) begin errors++; $display("FAIL reset_left got %h exp 0", left); end
    checks++; if (right !== '0) begin errors++; $display("FAIL reset_right got %h exp 0", right); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
    checks++; if (slot_bits !== '0) begin errors++; $display("FAIL reset_slot got %0d exp 0", slot_bits); end
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_standard();
    send_frame(32'h1234, 32'hABCD, 16);
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL std_first_frame pulses got %0d exp 0", pulse_cnt); end
    for (int f = 2; f <= 3; f++) begin
      send_frame(32'h1234, 32'hABCD, 16);
      checks++; if (pulse_cnt !== f - 1) begin errors++; $display("FAIL std_pulses f%0d got %0d exp %0d", f, pulse_cnt, f - 1); end
      checks++; if (left !== 16'h1234) begin errors++; $display("FAIL std_left f%0d got %h exp 1234", f, left); end
      checks++; if (right !== 16'hABCD) begin errors++; $display("FAIL std_right f%0d got %h exp abcd", f, right); end
      checks++; if (slot_bits !== 6'd16) begin errors++; $display("FAIL std_slot f%0d got %0d exp 16", f, slot_bits); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] rw;
    int base;
    rw = 32'h0000C3E1;
    send_word(32'h5A5A, 16, 1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b1, rw[15-i]);
    @(negedge clk_sys);
    bck = 1'b0; lrck = 1'b0; data = rw[0];
    repeat (3) @(negedge clk_sys);
    base = pulse_cnt;
    bck = 1'b1;
    model_rise(1'b0, rw[0]);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk_sys); #1;
      checks++;
      if (sample_valid !== ((e == 3) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL latency_edge%0d valid got %b exp %b", e, sample_valid, (e == 3)); end
    end
    repeat (2) @(negedge clk_sys);
    checks++; if (pulse_cnt !== base + 1) begin errors++; $display("FAIL latency_pulses got %0d exp %0d", pulse_cnt, base + 1); end
    checks++; if (left !== 16'h5A5A) begin errors++; $display("FAIL latency_left got %h exp 5a5a", left); end
    checks++; if (right !== 16'hC3E1) begin errors++; $display("FAIL latency_right got %h exp c3e1", right); end
  endtask

  task automatic test_truncation();
    send_frame(32'h89ABCD, 32'h123456, 24);
    checks++; if (left !== 16'h89AB) begin errors++; $display("FAIL trunc_left got %h exp 89ab", left); end
    checks++; if (right !== 16'h1234) begin errors++; $display("FAIL trunc_right got %h exp 1234", right); end
    checks++; if (slot_bits !== 6'd24) begin errors++; $display("FAIL trunc_slot got %0d exp 24", slot_bits); end
    checks++; if (pulse_cnt !== m_pulses) begin errors++; $display("FAIL trunc_pulses got %0d exp %0d", pulse_cnt, m_pulses); end
  endtask

  task automatic test_short();
    send_frame(32'hA5, 32'h3C, 8);
    checks++; if (left !== 16'hA500) begin errors++; $display("FAIL short_left got %h exp a500", left); end
    checks++; if (right !== 16'h3C00) begin errors++; $display("FAIL short_right got %h exp 3c00", right); end
    checks++; if (slot_bits !== 6'd8) begin errors++; $display("FAIL short_slot got %0d exp 8", slot_bits); end
    checks++; if (pulse_cnt !== m_pulses) begin errors++; $display("FAIL short_pulses got %0d exp %0d", pulse_cnt, m_pulses); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] lw, rw;
    int base;
    lw = 32'h1357; rw = 32'h2468;
    for (int i = 0; i < 5; i++) send_bit(1'b0, lw[15-i]);
    @(negedge clk_sys);
    bck = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1 reset = 1'b1;
    #1;
    checks++; if (left !== '0) begin errors++; $display("FAIL rstmid_left got %h exp 0", left); end
    checks++; if (right !== '0) begin errors++; $display("FAIL rstmid_right got %h exp 0", right); end
    checks++; if (slot_bits !== '0) begin errors++; $display("FAIL rstmid_slot got %0d exp 0", slot_bits); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", sample_valid); end
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    base = pulse_cnt;
    for (int i = 5; i < 16; i++) send_bit((i == 15) ? 1'b1 : 1'b0, lw[15-i]);
    send_word(rw, 16, 1'b1);
    checks++; if (pulse_cnt !== base) begin errors++; $display("FAIL rstmid_nopulse got %0d exp %0d", pulse_cnt, base); end
    send_frame(lw, rw, 16);
    checks++; if (pulse_cnt !== base + 1) begin errors++; $display("FAIL rstmid_pulse got %0d exp %0d", pulse_cnt, base + 1); end
    checks++; if (left !== 16'h1357) begin errors++; $display("FAIL rstmid_pair_left got %h exp 1357", left); end
    checks++; if (right !== 16'h2468) begin errors++; $display("FAIL rstmid_pair_right got %h exp 2468", right); end
  endtask

  task automatic test_stuck();
    int base;
    base = pulse_cnt;
    for (int i = 0; i < 100; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    checks++; if (pulse_cnt !== base) begin errors++; $display("FAIL stuck_pulse got %0d exp %0d", pulse_cnt, base); end
    send_word(32'hF00D, 16, 1'b0);
    checks++; if (slot_bits !== 6'd63) begin errors++; $display("FAIL stuck_slot got %0d exp 63", slot_bits); end
    checks++; if (pulse_cnt !== base) begin errors++; $display("FAIL stuck_left_commit got %0d exp %0d", pulse_cnt, base); end
    send_word(32'hBEEF, 16, 1'b1);
    checks++; if (pulse_cnt !== m_pulses) begin errors++; $display("FAIL stuck_pair_pulses got %0d exp %0d", pulse_cnt, m_pulses); end
    checks++; if (left !== m_left) begin errors++; $display("FAIL stuck_pair_left got %h exp %h", left, m_left); end
    send_frame(32'h7E81, 32'h0FF0, 16);
    checks++; if (left !== 16'h7E81) begin errors++; $display("FAIL stuck_resume_left got %h exp 7e81", left); end
    checks++; if (right !== 16'h0FF0) begin errors++; $display("FAIL stuck_resume_right got %h exp 0ff0", right); end
    checks++; if (slot_bits !== 6'd16) begin errors++; $display("FAIL stuck_resume_slot got %0d exp 16", slot_bits); end
  endtask

  task automatic test_random();
    int n;
    logic [31:0] lw, rw;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(8, 32);
      lw = $urandom; rw = $urandom;
      if (n < 32) begin
        lw = lw & ((32'd1 << n) - 1);
        rw = rw & ((32'd1 << n) - 1);
      end
      send_frame(lw, rw, n);
      checks++; if (pulse_cnt !== m_pulses) begin errors++; $display("FAIL rand_pulses f%0d got %0d exp %0d", f, pulse_cnt, m_pulses); end
      checks++; if (left !== m_left) begin errors++; $display("FAIL rand_left f%0d n%0d got %h exp %h", f, n, left, m_left); end
      checks++; if (right !== m_right) begin errors++; $display("FAIL rand_right f%0d n%0d got %h exp %h", f, n, right, m_right); end
      checks++; if (32'(slot_bits) !== m_slot) begin errors++; $display("FAIL rand_slot f%0d got %0d exp %0d", f, slot_bits, m_slot); end
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_latency();
    test_truncation();
    test_short();
    test_reset_mid();
    test_stuck();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
